// File: rtl/exe_mem_pipe_reg_pkg.sv
// Shared types and constants for the EXE->MEM pipeline register (package pipe_pkg).
// Optional feature macro used by the top: EXE_MEM_PIPE_REG_PERF_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int CTRL_WB = 0;
    localparam int CTRL_MR = 1;
    localparam int CTRL_MW = 2;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEST_W = 4;
    localparam int DEF_CTRL_W = 3;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/exe_mem_pipe_reg_skid_buf.sv
// Two-entry skid buffer (module skid_buf): main register drives the output,
// skid register absorbs one beat so in_ready can stay registered.
module skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    pipe_state_e  state_r;
    pipe_state_e  state_nxt_s;
    logic [W-1:0] main_r;
    logic [W-1:0] skid_r;
    logic         in_ready_r;
    logic         in_fire_s;
    logic         out_fire_s;
    logic         load_main_in_s;
    logic         load_main_skid_s;
    logic         load_skid_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = (state_r != EMPTY) & out_ready;

    // Next-state and register-load decode; flush overrides everything below reset.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nxt_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        load_main_in_s = 1'b1;
                        state_nxt_s    = ONE;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        load_main_in_s = 1'b1;
                    end else if (in_fire_s) begin
                        load_skid_s = 1'b1;
                        state_nxt_s = TWO;
                    end else if (out_fire_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        load_main_skid_s = 1'b1;
                        state_nxt_s      = ONE;
                    end else begin
                        state_nxt_s = TWO;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                end
            endcase
        end
    end

    // State, payload and registered in_ready update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= EMPTY;
            main_r     <= '0;
            skid_r     <= '0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != TWO);
            if (load_main_in_s) begin
                main_r <= in_data;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (state_r != EMPTY);
    assign out_data  = main_r;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, skid buffer and flush.
// Define EXE_MEM_PIPE_REG_PERF_EN to add the saturating stall_cnt output.
module exe_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_val_rm,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [DEST_W-1:0] out_dest
`ifdef EXE_MEM_PIPE_REG_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + DEST_W;

    logic [PAY_W-1:0]  in_pay_s;
    logic [PAY_W-1:0]  out_pay_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic              out_valid_s;

    assign in_pay_s = {in_ctrl, in_alu_res, in_val_rm, in_dest};

    skid_buf #(
        .W(PAY_W)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_pay_s),
        .out_valid(out_valid_s),
        .out_ready(out_ready),
        .out_data (out_pay_s)
    );

    assign {main_ctrl_s, out_alu_res, out_val_rm, out_dest} = out_pay_s;
    assign out_valid = out_valid_s;
    // A bubble must never write back or touch memory, so every control bit is gated.
    assign out_ctrl  = out_valid_s ? main_ctrl_s : {CTRL_W{1'b0}};

`ifdef EXE_MEM_PIPE_REG_PERF_EN
    logic [31:0] stall_cnt_r;

    // Count cycles where MEM back-pressures a valid beat; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (out_valid_s && !out_ready && (stall_cnt_r != STALL_CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed, scoreboard-based bench for exe_mem_pipe_reg.
// Build with EXE_MEM_PIPE_REG_PERF_EN defined to also exercise stall_cnt.
module tb_exe_mem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ctrl;
    logic [31:0] in_alu_res;
    logic [31:0] in_val_rm;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ctrl;
    logic [31:0] out_alu_res;
    logic [31:0] out_val_rm;
    logic [3:0]  out_dest;
`ifdef EXE_MEM_PIPE_REG_PERF_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  dest;
    } beat_t;

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_pop = 0;

    always #5 clk = ~clk;

    exe_mem_pipe_reg dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_alu_res (in_alu_res),
        .in_val_rm  (in_val_rm),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_alu_res(out_alu_res),
        .out_val_rm (out_val_rm),
        .out_dest   (out_dest)
`ifdef EXE_MEM_PIPE_REG_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ctrl, input logic [31:0] alu);
        logic [31:0] a;
        a          = alu;
        in_valid   = 1'b1;
        in_ctrl    = ctrl;
        in_alu_res = a;
        in_val_rm  = ~a;
        in_dest    = a[3:0];
    endtask

    // Scoreboard the handshakes of the coming edge, then advance to the next negedge.
    task automatic tick();
        beat_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_beat: observed alu=0x%0h expected=no beat", out_alu_res);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    n_pop++;
                    chk("sb_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                    chk("sb_alu", out_alu_res, e.alu);
                    chk("sb_rm", out_val_rm, e.rm);
                    chk("sb_dest", 32'(out_dest), 32'(e.dest));
                end
            end
            if (in_valid && in_ready && !flush) begin
                e.ctrl = in_ctrl;
                e.alu  = in_alu_res;
                e.rm   = in_val_rm;
                e.dest = in_dest;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_ctrl    = 3'd0;
        in_alu_res = 32'd0;
        in_val_rm  = 32'd0;
        in_dest    = 4'd0;
        out_ready  = 1'b0;

        // 1. reset and idle
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_out_alu", out_alu_res, 32'd0);
        chk("rst_out_rm", out_val_rm, 32'd0);
        chk("rst_out_dest", 32'(out_dest), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // 2. streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            drive(3'b001, 32'(i));
            tick();
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_latency", out_alu_res, 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_sb_empty", 32'(sb_q.size()), 32'd0);

        // 3. back-pressure into TWO, then release
        out_ready = 1'b0;
        drive(3'b011, 32'hA);
        tick();
        chk("bp_one_in_ready", 32'(in_ready), 32'd1);
        chk("bp_one_out", out_alu_res, 32'hA);
        drive(3'b101, 32'hB);
        tick();
        chk("bp_two_in_ready", 32'(in_ready), 32'd0);
        drive(3'b110, 32'hC);
        repeat (2) tick();
        chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_out", out_alu_res, 32'hA);
        chk("bp_hold_ctrl", 32'(out_ctrl), 32'd3);
        n_pop     = 0;
        out_ready = 1'b1;
        tick();
        chk("bp_rel_out_b", out_alu_res, 32'hB);
        chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_rel_out_c", out_alu_res, 32'hC);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_pop_count", 32'(n_pop), 32'd3);
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // 4. flush while full, with a beat offered in the same cycle
        out_ready = 1'b0;
        drive(3'b001, 32'h11);
        tick();
        drive(3'b001, 32'h22);
        tick();
        chk("fl_two_in_ready", 32'(in_ready), 32'd0);
        drive(3'b111, 32'h33);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_no_ghost", 32'(out_valid), 32'd0);

        // 5. bubble gating of control bits
        drive(3'b111, 32'h5A);
        tick();
        chk("bub_ctrl_valid", 32'(out_ctrl), 32'd7);
        in_valid = 1'b0;
        tick();
        chk("bub_out_valid", 32'(out_valid), 32'd0);
        chk("bub_out_ctrl", 32'(out_ctrl), 32'd0);
        chk("bub_alu_hold", out_alu_res, 32'h5A);

`ifdef EXE_MEM_PIPE_REG_PERF_EN
        // 6. stall counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        chk("perf_rst0", stall_cnt, 32'd0);
        out_ready = 1'b0;
        drive(3'b001, 32'h77);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("perf_five", stall_cnt, 32'd5);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        sb_q.delete();
        chk("perf_flush_keep", stall_cnt, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perf_rst_clear", stall_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
- Parametrised EXE->MEM pipeline register, the successor to the fixed 32-bit stage register.
- Adds a valid/ready handshake, a 2-entry skid buffer for full-rate back-pressure, and a synchronous flush.
- Sits between the EXE stage and the MEM stage.
- Carries control bits (wb_enable, mem_read, mem_write), ALU result, store data (val_rm) and destination register index.

Parameters:
- DATA_W, 32, width of alu_res and val_rm.
- DEST_W, 4, width of destination register index.
- CTRL_W, 3, control bit count; bit 0 = wb_enable, bit 1 = mem_read, bit 2 = mem_write, bits above 2 passed through.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous pipeline flush, active-high.
- in_valid  in  1  EXE presents a beat.
- in_ready  out  1  stage accepts a beat; registered.
- in_ctrl  in  CTRL_W  control bits.
- in_alu_res  in  DATA_W  ALU result.
- in_val_rm  in  DATA_W  store data.
- in_dest  in  DEST_W  destination register.
- out_valid  out  1  beat available to MEM.
- out_ready  in  1  MEM accepts the beat.
- out_ctrl  out  CTRL_W  control bits; forced 0 when out_valid=0.
- out_alu_res  out  DATA_W  ALU result.
- out_val_rm  out  DATA_W  store data.
- out_dest  out  DEST_W  destination register.
- stall_cnt  out  32  present only with EXE_MEM_PIPE_REG_PERF_EN.

Behaviour:
- Handshake terms:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register (drives the outputs) and skid register.
- States: EMPTY, ONE (main valid), TWO (main and skid valid).
- in_ready = (state != TWO). It is registered, with no combinational path from out_ready.
- EMPTY:
  - in_fire: main<=in, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire: main<=in, stay in ONE.
  - in_fire & !out_fire: skid<=in, go to TWO.
  - !in_fire & out_fire: go to EMPTY.
  - Neither: hold.
- TWO:
  - out_fire: main<=skid, go to ONE.
  - Otherwise hold. in_valid is ignored because in_ready=0.
- Latency and throughput:
  - 1 cycle from in_fire in EMPTY to out_valid=1.
  - Sustained throughput 1 beat/cycle when out_ready=1.
  - Strict FIFO order; no beat duplicated or lost except by flush.
- out_valid = (state != EMPTY).
- Payload outputs come from main. They hold their last value while out_valid=0, but out_ctrl is gated to 0 so a bubble never writes back or accesses memory.
- out_* are stable while out_valid=1 and out_ready=0.
- rst (highest priority):
  - state<=EMPTY.
  - main and skid payloads <=0.
  - After reset: out_valid=0, out_ctrl=0, out_alu_res=0, out_val_rm=0, out_dest=0, in_ready=1.
- flush (below rst):
  - state<=EMPTY. Both entries invalidated; payload registers are not cleared.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle counts as consumed by MEM.
  - in_ready=1 on the following cycle.
- rst or flush while in TWO discards both entries.
- Upper control bits (above bit 2) follow the same gating as bits 0-2.

Optional Feature:
- Macro: EXE_MEM_PIPE_REG_PERF_EN.
- Defined:
  - stall_cnt port exists.
  - It increments each cycle with out_valid=1 & out_ready=0, saturating at 32'hFFFF_FFFF.
  - Cleared by rst; unaffected by flush.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - State enum typedef (EMPTY/ONE/TWO).
  - Control bit index constants CTRL_WB=0, CTRL_MR=1, CTRL_MW=2.
  - Default width constants.
- Sub-module skid_buf:
  - Generic over a single packed payload width, W.
  - Contains the state machine, main/skid registers and flush.
- Top-level:
  - Packs {ctrl, alu_res, val_rm, dest} into skid_buf and unpacks its output.
  - Applies out_ctrl gating.
  - Hosts the optional stall counter.

Test Plan:
1. Reset then idle: rst high 2 cycles -> out_valid=0, out_ctrl=0, out_alu_res=0, in_ready=1; all stay so with in_valid=0.
2. Streaming: out_ready=1, beats alu_res=1..8 on consecutive cycles -> out_alu_res=1..8 on consecutive cycles, each one cycle after its input, in_ready constantly 1.
3. Back-pressure: out_ready=0 while beats 0xA then 0xB are sent -> state TWO, in_ready=0, out holds 0xA. Beat 0xC held on input. Raise out_ready -> output sequence 0xA, 0xB, 0xC with no loss.
4. Flush in TWO: fill with 0x11 and 0x22, assert flush with in_valid=1 (0x33) -> next cycle out_valid=0, out_ctrl=0, in_ready=1. 0x33 never appears.
5. Bubble gating: after a beat with ctrl=3'b111 drains, out_valid=0 -> out_ctrl=3'b000 while out_alu_res keeps its last value.
6. PERF_EN: hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5; flush -> still 5; rst -> 0.
